// File: rtl/mem_copy_pkg.sv
// Shared constants and FSM state type for the memory block-copy engine.
package mem_copy_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_block_copy.sv
// Block-copy engine: reads src+i, writes dst+i, ascending, 2 cycles per word.
// Optional running checksum of copied words is enabled by MEM_COPY_CHECKSUM_EN.
module mem_block_copy
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              enable,
  output logic              R_W,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] D_In,
  input  logic [DATA_W-1:0] D_Out,
  output logic [DATA_W-1:0] checksum
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, idx_inc;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              enable_q, enable_d, rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      enable_q <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      enable_q <= enable_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    idx_inc = idx_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          cnt_d   = count;
          idx_d   = '0;
          state_d = (count != '0) ? READ : DONE;
        end
      end
      READ:  state_d = WRITE;
      WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc < cnt_q) ? READ : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    enable_d = (state_d == READ) || (state_d == WRITE);
    rw_d     = (state_d == WRITE);
    addr_d   = '0;
    din_d    = '0;
    case (state_d)
      READ:  addr_d = src_d + idx_d;
      WRITE: begin
        addr_d = dst_d + idx_d;
        din_d  = D_Out;
      end
      default: ;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign enable  = enable_q;
  assign R_W     = rw_q;
  assign Address = addr_q;
  assign D_In    = din_q;

`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  // Word is accumulated on the same edge it is captured for the write.
  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && start) csum_d = '0;
    else if (state_q == READ)     csum_d = csum_q + D_Out;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule
